// File: rtl/sig_mag_pack.sv
// Packs consecutive 2-bit {sig,mag} quantizer samples into WORD_W-bit words
// and presents them on a valid/ready output with sticky overflow and a word counter.
module sig_mag_pack #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sig,
  input  logic              mag,
  input  logic              clr_ovf,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int N     = WORD_W / 2;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  // The newest sample enters at the top, so after N-1 shifts sample 0 sits in the LSBs.
  function automatic logic [WORD_W-1:0] pack_word(input logic [WORD_W-3:0] partial,
                                                   input logic s, input logic m);
    return {s, m, partial};
  endfunction

  logic [WORD_W-3:0] sr_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic [WORD_W-1:0] word_p0;
  logic              word_done;
  logic              out_free;
  logic              load_p1;
  logic              drop_p1;

  always_comb begin
    word_p0   = pack_word(sr_p0, sig, mag);
    word_done = en && (idx_p0 == IDX_LAST);
    out_free  = !out_valid || out_ready;
    load_p1   = word_done && out_free;
    drop_p1   = word_done && !out_free;
  end

  // Stage p0: sample capture; en low aborts the partial word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_p0  <= '0;
      idx_p0 <= '0;
    end else if (!en) begin
      sr_p0  <= '0;
      idx_p0 <= '0;
    end else begin
      sr_p0  <= word_p0[WORD_W-1:2];
      idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
    end
  end

  // Stage p1: output register; a completed word loads straight from the capture stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      word_cnt  <= '0;
    end else if (load_p1) begin
      out_data  <= word_p0;
      out_valid <= 1'b1;
      word_cnt  <= word_cnt + CNT_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A drop on the same edge as a clear must leave the flag set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop_p1) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sig_mag_pack.sv
// Scoreboard bench for sig_mag_pack: expected words are queued as stimulus is
// driven and compared whenever word_cnt shows that a new word was loaded.
module tb_sig_mag_pack;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              sig;
  logic              mag;
  logic              clr_ovf;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              overflow;
  logic [CNT_W-1:0]  word_cnt;

  int checks   = 0;
  int failures = 0;

  logic [WORD_W-1:0] exp_q[$];
  logic [CNT_W-1:0]  mon_cnt = '0;
  logic [WORD_W-1:0] exp_word;

  sig_mag_pack #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .sig(sig), .mag(mag), .clr_ovf(clr_ovf),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every increment of word_cnt must correspond to the next queued word
  always @(negedge clk) begin
    if (!reset) begin
      mon_cnt = '0;
    end else if (word_cnt !== mon_cnt) begin
      checks++;
      if (word_cnt !== CNT_W'(mon_cnt + 1)) begin
        failures++;
        $display("FAIL word_cnt_step: got %0d expected %0d", word_cnt, CNT_W'(mon_cnt + 1));
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word: got %08h expected no word", out_data);
      end else begin
        exp_word = exp_q.pop_front();
        if (out_data !== exp_word) begin
          failures++;
          $display("FAIL word_data: got %08h expected %08h", out_data, exp_word);
        end
      end
      mon_cnt = word_cnt;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; en = 1'b0; sig = 1'b0; mag = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    checks++; if (word_cnt !== '0) begin failures++; $display("FAIL rst_word_cnt: got %0d expected 0", word_cnt); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_data: got %08h expected 0", out_data); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_idle_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_throughput();
    logic [7:0] pa;
    logic [7:0] pb;
    logic [7:0] pat;
    do_reset();
    pa = 8'h36;  // samples {1,0},{0,1},{1,1},{0,0}, sample 0 in the LSBs
    pb = 8'h1B;  // samples {1,1},{1,0},{0,1},{0,0}
    exp_q.push_back(32'h36363636);
    exp_q.push_back(32'h36363636);
    exp_q.push_back(32'h1B1B1B1B);
    out_ready = 1'b1;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (c > 0) begin
        checks++;
        if (out_valid !== ((c % 16) == 0)) begin
          failures++;
          $display("FAIL thr_valid_c%0d: got %b expected %b", c, out_valid, ((c % 16) == 0));
        end
      end
      en = 1'b1;
      pat = (c < 32) ? pa : pb;
      {sig, mag} = pat[2*(c%4) +: 2];
    end
    @(negedge clk);
    en = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL thr_last_valid: got %b expected 1", out_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL thr_overflow: got %b expected 0", overflow); end
    checks++; if (word_cnt !== 16'd3) begin failures++; $display("FAIL thr_word_cnt: got %0d expected 3", word_cnt); end
    @(negedge clk);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL thr_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_partial();
    do_reset();
    exp_q.push_back(32'h55555555);
    out_ready = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 23) begin
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL part_early_valid: got %b expected 0", out_valid); end
      end
      en = !(c >= 5 && c < 8);
      {sig, mag} = (c < 5) ? 2'b11 : 2'b01;
    end
    @(negedge clk);
    en = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL part_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 32'h55555555) begin failures++; $display("FAIL part_data: got %08h expected 55555555", out_data); end
    checks++; if (word_cnt !== 16'd1) begin failures++; $display("FAIL part_word_cnt: got %0d expected 1", word_cnt); end
    @(negedge clk);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL part_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    exp_q.push_back(32'h55555555);
    out_ready = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (c == 31) begin
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL bp_early_overflow: got %b expected 0", overflow); end
      end
      en = 1'b1;
      {sig, mag} = (c < 16) ? 2'b01 : 2'b10;
    end
    @(negedge clk);
    en = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 32'h55555555) begin failures++; $display("FAIL bp_hold_data: got %08h expected 55555555", out_data); end
    checks++; if (word_cnt !== 16'd1) begin failures++; $display("FAIL bp_word_cnt: got %0d expected 1", word_cnt); end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bp_clr: got %b expected 0", overflow); end
    checks++; if (out_data !== 32'h55555555) begin failures++; $display("FAIL bp_clr_data: got %08h expected 55555555", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_consume: got %b expected 0", out_valid); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_consume_complete();
    do_reset();
    exp_q.push_back(32'h55555555);
    exp_q.push_back(32'hAAAAAAAA);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (c == 31) begin
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL cc_pre_valid: got %b expected 1", out_valid); end
      end
      en = 1'b1;
      {sig, mag} = (c < 16) ? 2'b01 : 2'b10;
      out_ready = (c == 31);
    end
    @(negedge clk);
    out_ready = 1'b0;
    en = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL cc_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 32'hAAAAAAAA) begin failures++; $display("FAIL cc_data: got %08h expected aaaaaaaa", out_data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL cc_overflow: got %b expected 0", overflow); end
    checks++; if (word_cnt !== 16'd2) begin failures++; $display("FAIL cc_word_cnt: got %0d expected 2", word_cnt); end
    @(negedge clk);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL cc_pending: got %0d expected 0", exp_q.size()); end
  endtask

  // Continues from the held 0xAAAAAAAA word left by test_consume_complete
  task automatic test_collision();
    out_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      en = 1'b1;
      {sig, mag} = 2'b11;
      clr_ovf = (c == 15);
    end
    @(negedge clk);
    en = 1'b0;
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL col_overflow: got %b expected 1", overflow); end
    checks++; if (out_data !== 32'hAAAAAAAA) begin failures++; $display("FAIL col_data: got %08h expected aaaaaaaa", out_data); end
    checks++; if (word_cnt !== 16'd2) begin failures++; $display("FAIL col_word_cnt: got %0d expected 2", word_cnt); end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL col_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_async_reset();
    do_reset();
    exp_q.push_back(32'h55555555);
    out_ready = 1'b0;
    for (int c = 0; c < 41; c++) begin
      @(negedge clk);
      en = 1'b1;
      {sig, mag} = (c < 16) ? 2'b01 : 2'b11;
    end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ar_pre_valid: got %b expected 1", out_valid); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ar_pre_overflow: got %b expected 1", overflow); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_valid: got %b expected 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ar_overflow: got %b expected 0", overflow); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL ar_data: got %08h expected 0", out_data); end
    checks++; if (word_cnt !== '0) begin failures++; $display("FAIL ar_word_cnt: got %0d expected 0", word_cnt); end
    {sig, mag} = 2'b10;
    exp_q.push_back(32'hAAAAAAAA);
    #4;
    reset = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (c == 16)) begin
        failures++;
        $display("FAIL ar_post_valid_c%0d: got %b expected %b", c, out_valid, (c == 16));
      end
    end
    en = 1'b0;
    checks++; if (out_data !== 32'hAAAAAAAA) begin failures++; $display("FAIL ar_post_data: got %08h expected aaaaaaaa", out_data); end
    checks++; if (word_cnt !== 16'd1) begin failures++; $display("FAIL ar_post_word_cnt: got %0d expected 1", word_cnt); end
    @(negedge clk);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL ar_pending: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; sig = 1'b0; mag = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
    test_reset();
    test_throughput();
    test_partial();
    test_backpressure();
    test_consume_complete();
    test_collision();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
